// File: rtl/divisor_dispatcher.sv
// Operand dispatcher for the algorithmic divider.
// Buffers numerator/denominator pairs in a small FIFO and issues them one
// at a time to the divider. It returns quotient/remainder over valid/ready.
// A zero denominator is resolved locally and never reaches the divider.
`timescale 1ns/1ps
module divisor_dispatcher #(
  parameter int tamanyo = 32,
  parameter int DEPTH   = 4
) (
  input  logic               CLK,
  input  logic               RSTa,
  input  logic               in_valid,
  output logic               in_ready,
  input  logic [tamanyo-1:0] in_num,
  input  logic [tamanyo-1:0] in_den,
  output logic               div_start,
  output logic [tamanyo-1:0] div_num,
  output logic [tamanyo-1:0] div_den,
  input  logic               div_done,
  input  logic [tamanyo-1:0] div_coc,
  input  logic [tamanyo-1:0] div_res,
  output logic               out_valid,
  input  logic               out_ready,
  output logic [tamanyo-1:0] out_coc,
  output logic [tamanyo-1:0] out_res,
  output logic               out_divzero,
  output logic               busy
);

  localparam int AW = $clog2(DEPTH);
  localparam int CW = AW + 1;
  localparam logic [CW-1:0] FULL_CNT = CW'(DEPTH);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    ISSUE = 2'd1,
    WAIT  = 2'd2,
    HOLD  = 2'd3
  } state_t;

  state_t state, state_nxt;

  logic [tamanyo-1:0] fifo_num [DEPTH];
  logic [tamanyo-1:0] fifo_den [DEPTH];
  logic [AW-1:0]      wr_ptr, rd_ptr;
  logic [CW-1:0]      count, count_nxt;
  logic               done_q;
  logic               push, pop, capture;
  logic               head_zero;
  logic [tamanyo-1:0] head_num, head_den;

  // No pass-through: a full FIFO refuses even if a pop happens this cycle.
  assign in_ready  = (count != FULL_CNT);
  assign push      = in_valid & in_ready;
  assign head_num  = fifo_num[rd_ptr];
  assign head_den  = fifo_den[rd_ptr];
  assign head_zero = (head_den == '0);
  assign count_nxt = count + CW'(push) - CW'(pop);

  // FIFO storage: payload only, no reset needed.
  always_ff @(posedge CLK) begin
    if (push) begin
      fifo_num[wr_ptr] <= in_num;
      fifo_den[wr_ptr] <= in_den;
    end
  end

  // FIFO pointers and occupancy; pointers wrap naturally (DEPTH is 2^n).
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
    end else begin
      if (push) wr_ptr <= wr_ptr + AW'(1);
      if (pop)  rd_ptr <= rd_ptr + AW'(1);
      count <= count_nxt;
    end
  end

  // FSM state register.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) state <= IDLE;
    else      state <= state_nxt;
  end

  // FSM next-state logic; Done is edge-detected so a level left high by
  // the previous operation is never mistaken for the current result.
  always_comb begin
    state_nxt = state;
    unique case (state)
      IDLE:    if (count != '0) state_nxt = head_zero ? HOLD : ISSUE;
      ISSUE:   state_nxt = WAIT;
      WAIT:    if (div_done && !done_q) state_nxt = HOLD;
      HOLD:    if (out_ready) state_nxt = IDLE;
      default: state_nxt = IDLE;
    endcase
  end

  // FSM output decode: FIFO pop and result capture strobes.
  always_comb begin
    pop     = 1'b0;
    capture = 1'b0;
    unique case (state)
      IDLE:    pop     = (count != '0);
      WAIT:    capture = div_done & ~done_q;
      default: ;
    endcase
  end

  // Registered control outputs, all derived from the next state.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      div_start <= 1'b0;
      out_valid <= 1'b0;
      busy      <= 1'b0;
      done_q    <= 1'b0;
    end else begin
      div_start <= (state_nxt == ISSUE);
      out_valid <= (state_nxt == HOLD);
      busy      <= (state_nxt != IDLE) || (count_nxt != '0);
      done_q    <= div_done;
    end
  end

  // Operand and result registers: operands are held from ISSUE through the
  // capture, and the result is held through HOLD until the transfer.
  always_ff @(posedge CLK or posedge RSTa) begin
    if (RSTa) begin
      div_num     <= '0;
      div_den     <= '0;
      out_coc     <= '0;
      out_res     <= '0;
      out_divzero <= 1'b0;
    end else begin
      if (pop && !head_zero) begin
        div_num <= head_num;
        div_den <= head_den;
      end
      if (pop && head_zero) begin
        out_coc     <= '1;
        out_res     <= head_num;
        out_divzero <= 1'b1;
      end else if (capture) begin
        out_coc     <= div_coc;
        out_res     <= div_res;
        out_divzero <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_divisor_dispatcher.sv
// Directed and randomized bench for divisor_dispatcher with a behavioural
// divider that keeps Done high until the next Start.
`timescale 1ns/1ps
module tb_divisor_dispatcher;
  localparam int W = 32;
  localparam int D = 4;

  logic         CLK = 1'b0;
  logic         RSTa = 1'b1;
  logic         in_valid = 1'b0;
  logic         in_ready;
  logic [W-1:0] in_num = '0, in_den = '0;
  logic         div_start;
  logic [W-1:0] div_num, div_den;
  logic         div_done = 1'b0;
  logic [W-1:0] div_coc = '0, div_res = '0;
  logic         out_valid;
  logic         out_ready = 1'b0;
  logic [W-1:0] out_coc, out_res;
  logic         out_divzero;
  logic         busy;

  int checks = 0;
  int failures = 0;

  divisor_dispatcher #(.tamanyo(W), .DEPTH(D)) dut (
    .CLK(CLK), .RSTa(RSTa),
    .in_valid(in_valid), .in_ready(in_ready), .in_num(in_num), .in_den(in_den),
    .div_start(div_start), .div_num(div_num), .div_den(div_den),
    .div_done(div_done), .div_coc(div_coc), .div_res(div_res),
    .out_valid(out_valid), .out_ready(out_ready),
    .out_coc(out_coc), .out_res(out_res), .out_divzero(out_divzero),
    .busy(busy)
  );

  always #5 CLK = ~CLK;

  // Divider model: samples Start mid-cycle, updates just after the edge.
  int div_lat = 5;
  bit rand_lat = 1'b0;
  bit sticky = 1'b0;
  initial begin : divider_model
    int cnt, drop;
    logic st;
    logic [W-1:0] n, d, sn, sd;
    cnt = 0; drop = 0; sn = '0; sd = 1;
    forever begin
      @(negedge CLK);
      st = div_start; n = div_num; d = div_den;
      @(posedge CLK); #1;
      if (RSTa) begin
        cnt = 0; drop = 0; div_done = 1'b0;
      end else if (st) begin
        cnt = rand_lat ? $urandom_range(1, 6) : div_lat;
        sn = n; sd = d;
        if (sticky) drop = 2; else div_done = 1'b0;
      end else begin
        if (drop > 0) begin
          drop--;
          if (drop == 0) div_done = 1'b0;
        end
        if (cnt > 0) begin
          cnt--;
          if (cnt == 0) begin
            div_done = 1'b1;
            div_coc = sn / sd;
            div_res = sn % sd;
          end
        end
      end
    end
  end

  // Start-pulse monitor.
  int start_cnt = 0;
  logic [W-1:0] last_num = '0, last_den = '0;
  always @(negedge CLK) begin
    if (div_start) begin
      start_cnt++;
      last_num = div_num;
      last_den = div_den;
    end
  end

  initial begin : watchdog
    #3000000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  task automatic chk(input string name, input logic [64:0] act, input logic [64:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got %0h expected %0h", name, act, exp);
    end
  endtask

  function automatic logic [64:0] model(input logic [W-1:0] n, input logic [W-1:0] d);
    if (d == '0) return {32'hFFFF_FFFF, n, 1'b1};
    return {n / d, n % d, 1'b0};
  endfunction

  task automatic wait_valid(input int limit, output int k);
    k = 0;
    while (!out_valid && k < limit) begin
      @(posedge CLK); #1;
      k++;
    end
  endtask

  typedef struct {
    logic [W-1:0] num;
    logic [W-1:0] den;
    logic [W-1:0] coc;
    logic [W-1:0] res;
    logic         dz;
  } vec_t;

  // One complete transaction with out_ready held high.
  task automatic run_vec(input int idx, input vec_t v);
    int s0, k;
    s0 = start_cnt;
    out_ready = 1'b1;
    in_valid = 1'b1; in_num = v.num; in_den = v.den;
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_valid(100, k);
    chk($sformatf("v%0d_valid", idx), out_valid, 1'b1);
    chk($sformatf("v%0d_result", idx), {out_coc, out_res, out_divzero}, {v.coc, v.res, v.dz});
    chk($sformatf("v%0d_starts", idx), start_cnt - s0, v.dz ? 0 : 1);
    if (v.dz) chk($sformatf("v%0d_dz_latency", idx), k, 1);
    else chk($sformatf("v%0d_operands", idx), {last_num, last_den}, {v.num, v.den});
    @(posedge CLK); #1;
    chk($sformatf("v%0d_valid_one_cycle", idx), out_valid, 1'b0);
  endtask

  localparam int NV = 10;
  vec_t vecs [NV];
  localparam int NR = 1000;
  logic [64:0] sb [$];

  initial begin
    int k, s0;
    bit ok, stable;
    logic [W-1:0] hc, hr;
    logic [64:0] fexp [5];

    vecs[0] = '{32'd100,        32'd7,          32'd14,         32'd2,          1'b0};
    vecs[1] = '{32'hDEAD_BEEF,  32'd0,          32'hFFFF_FFFF,  32'hDEAD_BEEF,  1'b1};
    vecs[2] = '{32'd0,          32'd5,          32'd0,          32'd0,          1'b0};
    vecs[3] = '{32'hFFFF_FFFF,  32'd1,          32'hFFFF_FFFF,  32'd0,          1'b0};
    vecs[4] = '{32'd5,          32'd7,          32'd0,          32'd5,          1'b0};
    vecs[5] = '{32'd7,          32'd7,          32'd1,          32'd0,          1'b0};
    vecs[6] = '{32'hFFFF_FFFF,  32'hFFFF_FFFF,  32'd1,          32'd0,          1'b0};
    vecs[7] = '{32'd0,          32'd0,          32'hFFFF_FFFF,  32'd0,          1'b1};
    vecs[8] = '{32'd1000,       32'd33,         32'd30,         32'd10,         1'b0};
    vecs[9] = '{32'h8000_0000,  32'd3,          32'h2AAA_AAAA,  32'd2,          1'b0};

    // Reset values.
    #2;
    chk("rst_outputs", {div_start, div_num, div_den, out_valid, out_coc, out_res, out_divzero, busy}, '0);
    chk("rst_in_ready", in_ready, 1'b1);
    repeat (3) @(posedge CLK);
    #1 RSTa = 1'b0;
    @(posedge CLK); #1;

    for (int i = 0; i < NV; i++) run_vec(i, vecs[i]);

    // Stale Done still high on entry to WAIT must not be captured.
    sticky = 1'b1; div_lat = 6;
    run_vec(20, '{32'd100, 32'd7, 32'd14, 32'd2, 1'b0});
    run_vec(21, '{32'd50,  32'd3, 32'd16, 32'd2, 1'b0});
    sticky = 1'b0; div_lat = 5;

    // FIFO full plus backpressure: five back-to-back pushes, consumer stalled.
    out_ready = 1'b0;
    ok = 1'b1;
    for (int i = 0; i < 5; i++) begin
      in_valid = 1'b1; in_num = 32'(60 + i); in_den = (i == 1) ? 32'd0 : 32'(i + 6);
      fexp[i] = model(in_num, in_den);
      if (!in_ready) ok = 1'b0;
      @(posedge CLK); #1;
    end
    chk("full_accept_5", ok, 1'b1);
    in_num = 32'd99; in_den = 32'd9;
    chk("full_in_ready_6th", in_ready, 1'b0);
    chk("full_busy", busy, 1'b1);
    @(posedge CLK); #1;
    in_valid = 1'b0;
    wait_valid(100, k);
    chk("bp_first_valid", out_valid, 1'b1);
    hc = out_coc; hr = out_res;
    s0 = start_cnt;
    stable = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (!out_valid || out_coc !== hc || out_res !== hr) stable = 1'b0;
    end
    chk("bp_stable", stable, 1'b1);
    chk("bp_no_start", start_cnt - s0, 0);
    out_ready = 1'b1;
    for (int i = 0; i < 5; i++) begin
      wait_valid(100, k);
      chk($sformatf("full_order%0d", i), {out_coc, out_res, out_divzero}, fexp[i]);
      @(posedge CLK); #1;
    end
    ok = 1'b1;
    for (int i = 0; i < 30; i++) begin
      if (out_valid) ok = 1'b0;
      @(posedge CLK); #1;
    end
    chk("full_no_extra", ok, 1'b1);
    chk("full_idle_busy", busy, 1'b0);

    // Reset in the middle of WAIT with three entries queued.
    out_ready = 1'b0; div_lat = 8;
    s0 = start_cnt;
    for (int i = 0; i < 4; i++) begin
      in_valid = 1'b1; in_num = 32'(200 + i); in_den = 32'd3;
      @(posedge CLK); #1;
    end
    in_valid = 1'b0;
    @(posedge CLK); #1;
    chk("midwait_started", start_cnt - s0, 1);
    chk("midwait_no_result", out_valid, 1'b0);
    RSTa = 1'b1;
    #1;
    chk("midrst_outputs", {div_start, div_num, div_den, out_valid, out_coc, out_res, out_divzero, busy}, '0);
    chk("midrst_in_ready", in_ready, 1'b1);
    @(posedge CLK); @(posedge CLK); #1;
    RSTa = 1'b0;
    s0 = start_cnt;
    ok = 1'b1;
    for (int i = 0; i < 20; i++) begin
      @(posedge CLK); #1;
      if (out_valid || busy || !in_ready) ok = 1'b0;
    end
    chk("postrst_quiet", ok, 1'b1);
    chk("postrst_no_start", start_cnt - s0, 0);
    div_lat = 5;
    run_vec(30, '{32'd77, 32'd10, 32'd7, 32'd7, 1'b0});

    // Random run with random latency, 10% zero denominators, random out_ready.
    rand_lat = 1'b1;
    fork
      begin : producer
        int pushed;
        logic [W-1:0] n, d;
        pushed = 0;
        while (pushed < NR) begin
          if ($urandom_range(3) != 0) begin
            n = $urandom;
            if ($urandom_range(9) == 0) d = '0;
            else if ($urandom_range(1) == 1) d = $urandom_range(1, 1000);
            else d = $urandom;
            in_valid = 1'b1; in_num = n; in_den = d;
          end else begin
            in_valid = 1'b0;
          end
          if (in_valid && in_ready) begin
            sb.push_back(model(in_num, in_den));
            pushed++;
          end
          @(posedge CLK); #1;
        end
        in_valid = 1'b0;
      end
      begin : consumer
        int got, cyc;
        logic [64:0] e;
        got = 0; cyc = 0;
        while (got < NR && cyc < 60000) begin
          out_ready = ($urandom_range(2) != 0);
          if (out_valid && out_ready) begin
            if (sb.size() == 0) begin
              chk("rand_unexpected_result", sb.size(), 1);
            end else begin
              e = sb.pop_front();
              chk($sformatf("rand%0d", got), {out_coc, out_res, out_divzero}, e);
            end
            got++;
          end
          @(posedge CLK); #1;
          cyc++;
        end
        chk("rand_count", got, NR);
      end
    join
    chk("rand_scoreboard_empty", sb.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/divisor_dispatcher.md
# divisor_dispatcher

Operand dispatcher that sits directly upstream of the algorithmic divider (`Divisor_Algoritmico`). It accepts numerator/denominator pairs over a valid/ready interface and buffers them in a small FIFO. It issues them one at a time to the divider with a single-cycle start pulse, collects quotient/remainder on the divider's done, and presents each result on a valid/ready output. It resolves divide-by-zero locally without involving the divider.

## Interface
- `tamanyo`, default 32: operand and result width in bits.
- `DEPTH`, default 4: operand FIFO depth in entries; must be a power of two and at least 2.

Ports:
- `CLK`  in  1  clock; all state updates on the rising edge.
- `RSTa`  in  1  asynchronous, active-high reset.
- `in_valid`  in  1  operand pair present.
- `in_ready`  out  1  FIFO not full; equals `!full`.
- `in_num`  in  tamanyo  numerator.
- `in_den`  in  tamanyo  denominator.
- `div_start`  out  1  registered start pulse to the divider `Start`.
- `div_num`  out  tamanyo  registered numerator to the divider `Num`.
- `div_den`  out  tamanyo  registered denominator to the divider `Den`.
- `div_done`  in  1  divider `Done`.
- `div_coc`  in  tamanyo  divider `Coc`.
- `div_res`  in  tamanyo  divider `Res`.
- `out_valid`  out  1  result held.
- `out_ready`  in  1  consumer accepts the result.
- `out_coc`  out  tamanyo  quotient.
- `out_res`  out  tamanyo  remainder.
- `out_divzero`  out  1  the held result came from a zero denominator.
- `busy`  out  1  FSM not in IDLE, or FIFO not empty.

## Operation
- **FIFO:** a push happens when `in_valid & in_ready`. A pop happens only in IDLE when the FIFO is not empty.
  - A push and a pop in the same cycle are both performed; the count is unchanged.
  - When the FIFO is full, `in_ready` is 0, with no pass-through.
  - Pointers wrap modulo `DEPTH`. The count is `$clog2(DEPTH)+1` bits.
- **FSM states:** IDLE, ISSUE, WAIT, HOLD.
- **IDLE:** if the FIFO is not empty, pop the head.
  - If the head `den != 0`: latch `div_num`/`div_den` and go to ISSUE.
  - If the head `den == 0`: load `out_coc` = all ones, `out_res` = num, `out_divzero` = 1, and go to HOLD.
- **ISSUE:** `div_start` = 1 for exactly this cycle; go to WAIT.
- **WAIT:** capture on a rising edge of `div_done`, detected against a registered `done_q`. This keeps the block correct for a level-held Done left over from a previous operation.
  - On capture: `out_coc <= div_coc`, `out_res <= div_res`, `out_divzero <= 0`, go to HOLD.
- **HOLD:** `out_valid` = 1. On `out_ready`, go to IDLE.
  - `out_coc`, `out_res` and `out_divzero` stay stable until the transfer.
- `div_num`/`div_den` stay stable from ISSUE through capture.
- Unsigned arithmetic only; no width conversion is performed.

## Timing
- **Reset values:**
  - `div_start`, `div_num`, `div_den`, `out_valid`, `out_coc`, `out_res`, `out_divzero`, `busy` are all 0.
  - `done_q` is 0, FIFO pointers and count are 0, and the FSM is in IDLE.
  - `in_ready` is 1 during and after reset.
- **Reset mid-operation:** the FIFO is emptied, in-flight results are discarded and the FSM returns to IDLE. The divider shares `RSTa`, so no abort handshake is needed.
- **Latency:** take a push accepted at edge N.
  - With an empty FIFO and the FSM in IDLE, the pop happens at edge N+1 and `div_start` is high during cycle N+1..N+2.
  - `out_valid` rises at the edge after the edge that samples `div_done` high.
  - Divide-by-zero: `out_valid` is high from edge N+1.
- **Throughput:** if `out_ready` = 1 while in HOLD, `out_valid` is high for one cycle. IDLE is then entered and the next pop happens one edge later. Minimum spacing of `div_start` pulses is divider latency + 4 cycles.
- **Simultaneous events:**
  - A push into a FIFO with one free entry while popping is accepted.
  - `div_done` high on entry to WAIT with `done_q` = 1 does not capture.
- `busy` is registered and is 0 only when IDLE and the count is 0.

## Test plan
- **Reset:** assert `RSTa` mid-WAIT with 3 entries queued -> all outputs 0, `in_ready` = 1, and no `div_start` follows until a new push.
- **Single divide:** push 100/7, `out_ready` = 1 -> exactly one `div_start` pulse with `div_num` = 100 and `div_den` = 7; then `out_coc` = 14, `out_res` = 2, `out_divzero` = 0, and `out_valid` is high for one cycle.
- **Zero denominator:** push 0xDEADBEEF/0 -> no `div_start`; `out_coc` = 0xFFFFFFFF, `out_res` = 0xDEADBEEF, `out_divzero` = 1, with `out_valid` one cycle after the pop.
- **FIFO full:** `out_ready` = 0, push 5 pairs with `DEPTH` = 4 -> the first goes to the divider, 4 are queued, and `in_ready` = 0 on the sixth offer. Results return in push order.
- **Backpressure:** hold `out_ready` = 0 for 20 cycles while in HOLD -> `out_coc`/`out_res` are stable, no new `div_start` is issued, and the FIFO keeps accepting until full.
- **Random run:** 1000 random pairs including 10% zero denominators, random `out_ready` -> every result matches `num/den` and `num%den`, or the zero rule; order is preserved and none are lost or duplicated.
